// File: rtl/poly_accumulate.sv
// Kyber polynomial accumulator: sums KDIM polynomials mod q into a pair
// buffer, then streams the reduced result out two coefficients per cycle.
module poly_accumulate #(
   parameter int DEPTH = 8,
   parameter int KDIM  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic             acc_in_valid,
   input  logic [15:0]      acc_din_1,
   input  logic [15:0]      acc_din_2,
   input  logic [DEPTH-1:0] in_index,
   output logic             acc_in_ok,
   output logic             acc_full,
   input  logic             readout,
   output logic [15:0]      acc_dout_1,
   output logic [15:0]      acc_dout_2,
   output logic [DEPTH-1:0] out_index,
   output logic             out_valid,
   output logic             done
);

   localparam int AW = DEPTH - 1;
   localparam int NP = 2 ** AW;
   localparam int PW = (KDIM > 1) ? $clog2(KDIM) : 1;
   localparam logic [12:0] Q = 13'd3329;

   typedef enum logic [2:0] {
      S_IDLE, S_ACCUM, S_DRAIN, S_FULL, S_READ
   } state_t;

   state_t r_state, w_next;

   logic [23:0]   r_mem [NP];
   logic [23:0]   r_rd;
   logic [AW-1:0] r_pair;
   logic [PW-1:0] r_pass;
   logic          r_dcnt;
   logic          r_s1_v, r_s1_first, r_s1_fwd;
   logic [AW-1:0] r_s1_a;
   logic [13:0]   r_s1_x1, r_s1_x2;
   logic [23:0]   r_s1_f;
   logic          r_s2_v;
   logic [AW-1:0] r_s2_a;
   logic [23:0]   r_s2_d;
   logic [AW:0]   r_raddr;
   logic [AW-1:0] r_oaddr;
   logic          r_ov, r_done;
   logic [11:0]   r_do1, r_do2;

   logic [AW-1:0] w_a;
   logic          w_accept, w_pair_last, w_pass_last;
   logic          w_hit1, w_hit2, w_issue, w_out_last;
   logic [11:0]   w_b1, w_b2;
   logic [23:0]   w_sum;
   logic          w_unused;

   // inputs carry sign + low 13 bits; (-q,q) maps to [0,q) by adding q
   function automatic logic [11:0] norm(input logic [13:0] x);
      logic [12:0] t;
      t = x[13] ? x[12:0] + Q : x[12:0];
      return t[11:0];
   endfunction

   function automatic logic [11:0] madd(input logic [11:0] a,
                                        input logic [11:0] b);
      logic [12:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= Q) s = s - Q;
      return s[11:0];
   endfunction

   assign w_unused = ^{in_index[0], acc_din_1[14:13], acc_din_2[14:13]};

   assign w_a         = in_index[DEPTH-1:1];
   assign w_accept    = (r_state == S_ACCUM) && acc_in_valid;
   assign w_pair_last = (r_pair == '1);
   assign w_pass_last = (r_pass == PW'(KDIM - 1));
   assign w_hit1      = r_s1_v && (r_s1_a == w_a);
   assign w_hit2      = r_s2_v && (r_s2_a == w_a);
   assign w_issue     = (r_state == S_READ) && readout && !r_raddr[AW];
   assign w_out_last  = r_ov && (r_oaddr == '1);

   // forwarded in-flight sums win over both the buffer and pass-0 zero
   assign w_b1  = r_s1_fwd ? r_s1_f[11:0]  : (r_s1_first ? 12'd0 : r_rd[11:0]);
   assign w_b2  = r_s1_fwd ? r_s1_f[23:12] : (r_s1_first ? 12'd0 : r_rd[23:12]);
   assign w_sum = {madd(w_b2, norm(r_s1_x2)), madd(w_b1, norm(r_s1_x1))};

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      acc_in_ok = 1'b0;
      acc_full  = 1'b0;
      unique case (r_state)
         S_IDLE:  if (set) w_next = S_ACCUM;
         S_ACCUM: begin
            acc_in_ok = 1'b1;
            if (w_accept && w_pair_last && w_pass_last) w_next = S_DRAIN;
         end
         S_DRAIN: if (r_dcnt) w_next = S_FULL;
         S_FULL: begin
            acc_full = 1'b1;
            if (readout) w_next = S_READ;
         end
         S_READ: begin
            acc_full = 1'b1;
            if (w_out_last) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (r_s2_v) r_mem[r_s2_a] <= r_s2_d;
      r_rd <= r_mem[w_a];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_do1 <= '0;
         r_do2 <= '0;
      end else if (w_issue) begin
         {r_do2, r_do1} <= r_mem[r_raddr[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pair     <= '0;
         r_pass     <= '0;
         r_dcnt     <= 1'b0;
         r_s1_v     <= 1'b0;
         r_s1_first <= 1'b0;
         r_s1_fwd   <= 1'b0;
         r_s1_a     <= '0;
         r_s1_x1    <= '0;
         r_s1_x2    <= '0;
         r_s1_f     <= '0;
         r_s2_v     <= 1'b0;
         r_s2_a     <= '0;
         r_s2_d     <= '0;
         r_raddr    <= '0;
         r_oaddr    <= '0;
         r_ov       <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_s1_v <= w_accept;
         if (w_accept) begin
            r_s1_a     <= w_a;
            r_s1_x1    <= {acc_din_1[15], acc_din_1[12:0]};
            r_s1_x2    <= {acc_din_2[15], acc_din_2[12:0]};
            r_s1_first <= (r_pass == '0);
            r_s1_fwd   <= w_hit1 || w_hit2;
            r_s1_f     <= w_hit1 ? w_sum : r_s2_d;
            r_pair     <= r_pair + 1'b1;
            if (w_pair_last)
               r_pass <= w_pass_last ? '0 : r_pass + 1'b1;
         end
         r_s2_v <= r_s1_v;
         r_s2_a <= r_s1_a;
         r_s2_d <= w_sum;
         r_dcnt <= (r_state == S_DRAIN) ? ~r_dcnt : 1'b0;
         r_ov   <= w_issue;
         if (w_issue) begin
            r_oaddr <= r_raddr[AW-1:0];
            r_raddr <= r_raddr + 1'b1;
         end
         if (w_out_last) r_raddr <= '0;
         r_done <= w_out_last;
      end
   end

   assign acc_dout_1 = {4'd0, r_do1};
   assign acc_dout_2 = {4'd0, r_do2};
   assign out_index  = {r_oaddr, 1'b0};
   assign out_valid  = r_ov;
   assign done       = r_done;

endmodule

// File: tb/tb_poly_accumulate.sv
// Directed bench for poly_accumulate: one KDIM=1 and one KDIM=3 instance
// share the input bus; each has its own set/readout.
module tb_poly_accumulate;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             acc_in_valid = 1'b0;
   logic [15:0]      din1 = '0, din2 = '0;
   logic [7:0]       idx = '0;
   logic [1:0]       set_k = '0, ro_k = '0;
   logic [1:0]       ok_k, full_k, ov_k, done_k;
   logic [1:0][15:0] d1_k, d2_k;
   logic [1:0][7:0]  oi_k;

   int n_chk = 0;
   int n_fail = 0;
   int exp_c [256];

   always #5 clk = ~clk;

   poly_accumulate #(.DEPTH(8), .KDIM(1)) u_k1 (
      .clk(clk), .reset(reset), .set(set_k[0]),
      .acc_in_valid(acc_in_valid), .acc_din_1(din1), .acc_din_2(din2),
      .in_index(idx), .acc_in_ok(ok_k[0]), .acc_full(full_k[0]),
      .readout(ro_k[0]), .acc_dout_1(d1_k[0]), .acc_dout_2(d2_k[0]),
      .out_index(oi_k[0]), .out_valid(ov_k[0]), .done(done_k[0]));

   poly_accumulate #(.DEPTH(8), .KDIM(3)) u_k3 (
      .clk(clk), .reset(reset), .set(set_k[1]),
      .acc_in_valid(acc_in_valid), .acc_din_1(din1), .acc_din_2(din2),
      .in_index(idx), .acc_in_ok(ok_k[1]), .acc_full(full_k[1]),
      .readout(ro_k[1]), .acc_dout_1(d1_k[1]), .acc_dout_2(d2_k[1]),
      .out_index(oi_k[1]), .out_valid(ov_k[1]), .done(done_k[1]));

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send(input int i, input logic [15:0] a,
                       input logic [15:0] b);
      acc_in_valid = 1'b1;
      idx = 8'(i);
      din1 = a;
      din2 = b;
      @(negedge clk);
      acc_in_valid = 1'b0;
   endtask

   task automatic pass_fill(input logic [15:0] a, input logic [15:0] b);
      for (int p = 0; p < 128; p++) send(2 * p, a, b);
   endtask

   task automatic start(input int k);
      set_k[k] = 1'b1;
      @(negedge clk);
      set_k[k] = 1'b0;
      check("in_ok_rise", ok_k[k], 1);
   endtask

   task automatic wait_full(input int k);
      check("in_ok_drop", ok_k[k], 0);
      for (int c = 0; c < 10 && !full_k[k]; c++) @(negedge clk);
      check("acc_full", full_k[k], 1);
   endtask

   task automatic fill_exp(input int v);
      for (int c = 0; c < 256; c++) exp_c[c] = v;
   endtask

   task automatic read_all(input int k, input bit pause);
      int np, nd, last_v;
      logic prev_ro;
      np = 0;
      nd = 0;
      last_v = -10;
      prev_ro = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         if (ov_k[k]) begin
            check("out_index", oi_k[k], 2 * np);
            if (exp_c[2 * np] >= 0)
               check("dout_1", d1_k[k], exp_c[2 * np]);
            if (exp_c[2 * np + 1] >= 0)
               check("dout_2", d2_k[k], exp_c[2 * np + 1]);
            np++;
            last_v = cyc;
         end
         if (pause && !prev_ro) check("pause_gap", ov_k[k], 0);
         if (done_k[k]) begin
            nd++;
            check("done_lat", cyc, last_v + 1);
         end
         if (nd > 0 && cyc > last_v + 3) break;
         ro_k[k] = pause ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         prev_ro = ro_k[k];
      end
      ro_k[k] = 1'b0;
      check("pair_count", np, 128);
      check("done_count", nd, 1);
      check("full_clear", full_k[k], 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ok", ok_k[1], 0);
      check("rst_full", full_k[1], 0);
      check("rst_valid", ov_k[1], 0);
      check("rst_done", done_k[1], 0);
      check("rst_oidx", oi_k[1], 0);
      check("rst_dout", {d1_k[1], d2_k[1]}, 0);
      check("rst_k1_ok", ok_k[0], 0);

      // abort a run mid-pass with reset
      start(1);
      for (int p = 0; p < 50; p++) send(2 * p, 16'd555, 16'd777);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_ok", ok_k[1], 0);
      check("mid_rst_full", full_k[1], 0);
      check("mid_rst_valid", ov_k[1], 0);
      check("mid_rst_done", done_k[1], 0);

      start(1);
      repeat (3) pass_fill(16'd1000, 16'd1000);
      wait_full(1);
      fill_exp(3000);
      read_all(1, 1'b0);

      start(1);
      repeat (3) pass_fill(16'd2000, 16'd2000);
      wait_full(1);
      fill_exp(2671);
      read_all(1, 1'b0);

      start(1);
      pass_fill(16'hFFFF, 16'hFFFF);
      repeat (2) pass_fill(16'd0, 16'd0);
      wait_full(1);
      fill_exp(3328);
      read_all(1, 1'b0);

      start(1);
      repeat (2) pass_fill(16'hF300, 16'hF300);
      pass_fill(16'd0, 16'd0);
      wait_full(1);
      fill_exp(2);
      read_all(1, 1'b0);

      start(0);
      for (int p = 0; p < 128; p++) send(2 * p, 16'(2 * p), 16'(2 * p + 1));
      wait_full(0);
      for (int c = 0; c < 256; c++) exp_c[c] = c;
      read_all(0, 1'b0);

      // index 4 three times back to back; pairs 252..255 left unwritten
      start(0);
      send(0, 16'd0, 16'd0);
      send(2, 16'd0, 16'd0);
      repeat (3) send(4, 16'd100, 16'd0);
      for (int p = 3; p < 126; p++) send(2 * p, 16'd0, 16'd0);
      wait_full(0);
      fill_exp(0);
      exp_c[4] = 300;
      for (int c = 252; c < 256; c++) exp_c[c] = -1;
      read_all(0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/poly_accumulate.md
Name: poly_accumulate

Overview:
- Downstream consumer of basemul_tomont in the Kyber matrix-vector product datapath.
- Receives KDIM successive polynomials as coefficient pairs, each pair tagged with a coefficient index, and accumulates them mod q=3329 into an internal buffer of 2^DEPTH coefficients.
- Once all passes are complete, streams the reduced sum polynomial out as pairs to the next stage (invNTT).

Parameters:
DEPTH, 8, log2 of coefficient count per polynomial (256 coefficients).
KDIM, 3, number of polynomials summed per result (Kyber k).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
set  input  1  start enable; IDLE->ACCUM when high
acc_in_valid  input  1  upstream pair valid
acc_din_1  input  16  coefficient at in_index, signed two's complement, range (-q,q)
acc_din_2  input  16  coefficient at in_index+1, same format
in_index  input  DEPTH  even coefficient index of pair; bit 0 ignored
acc_in_ok  output  1  block accepts input this cycle
acc_full  output  1  all KDIM passes accumulated, result ready
readout  input  1  downstream request/enable for output streaming
acc_dout_1  output  16  result coefficient at out_index, range [0,q)
acc_dout_2  output  16  result coefficient at out_index+1
out_index  output  DEPTH  even index of output pair
out_valid  output  1  output pair valid this cycle
done  output  1  one-cycle pulse after last output pair

Behaviour:
- Reset (sync, active-high): state IDLE; acc_in_ok, acc_full, out_valid, done, acc_dout_1/2, out_index all 0; pair and pass counters 0. Buffer contents are not cleared; pass 0 overwrites every address.
- Reset mid-operation (any state): same as above; partial sums discarded; pipeline writes in flight are suppressed.
- Storage: 2^(DEPTH-1) words of 2x12 bits, addressed by in_index[DEPTH-1:1]; one pair read and one pair written per cycle.
- States: IDLE, ACCUM, DRAIN, FULL, READ.
- IDLE: set=1 -> ACCUM. acc_in_ok rises the following cycle.
- ACCUM: acc_in_ok=1. A pair is accepted on a cycle with acc_in_valid && acc_in_ok.
  - Pipeline stage 0: read buffer.
  - Stage 1: normalise inputs (x<0 -> x+q), then add.
  - Stage 2: write.
  - Accept-to-write latency is 2 cycles.
- Arithmetic: pass 0 stores the normalised input; later passes store s+x, minus q if >= q. 13-bit intermediate; stored values are always in [0,q).
- Hazard: if the accepted address equals the address in stage 1 or stage 2, the newest in-flight sum is forwarded instead of the stale buffer value. Back-to-back repeated indices must accumulate correctly.
- Counting:
  - pair_cnt counts accepts, not distinct indices.
  - At 2^(DEPTH-1) accepts, pair_cnt wraps to 0 and pass_cnt increments.
  - On the final accept of pass KDIM-1, acc_in_ok drops the next cycle and the state goes to DRAIN.
- DRAIN: 2 cycles to retire the pipeline -> FULL. acc_full=1 from FULL entry until READ exits.
- FULL: readout=1 -> READ. acc_in_valid is ignored in FULL/READ/DRAIN/IDLE.
- READ:
  - Each cycle readout=1 issues a read at addr 0,1,...
  - One cycle later: out_valid=1, out_index=2*addr, data presented.
  - readout=0 pauses the stream: out_valid=0 the next cycle, address held.
  - After pair index 2^DEPTH-2 is presented, done=1 for exactly one cycle (the cycle after the last out_valid). acc_full clears and the state returns to IDLE with counters 0.
- set held high in IDLE immediately starts a new accumulation (KDIM passes again).

Test Plan:
- Reset: assert reset 2 cycles mid-ACCUM -> next cycle acc_in_ok=0, acc_full=0, out_valid=0, done=0; new run from set yields results unaffected by the aborted data.
- KDIM=1, feed pairs (i,i+1) for i=0..254 with value = index -> readout gives acc_dout_1=i, acc_dout_2=i+1, out_index=i for all 128 pairs; done one cycle after pair 254.
- KDIM=3, every coefficient 1000 each pass -> all outputs 3000. Repeat with 2000 -> all outputs 2671 (6000 mod 3329).
- Negative input: pass 0 all 0xFFFF (-1), passes 1-2 all 0 -> all outputs 3328. Pass 0 -3328, pass 1 -3328, pass 2 0 -> all outputs 2.
- Hazard: KDIM=1, within the pass drive in_index=4 on three consecutive accepts with din_1=100 (other accepts cover remaining indices with 0) -> coefficient 4 = 300; no lost update.
- Readout pause: in READ, toggle readout 1,0,0,1 -> out_valid gaps match, no pair skipped or duplicated, out_index strictly 0,2,4,...; done asserted once.
